write_output: RTL and testbench
===============================

Name: write_output

Overview:
- Result-side counterpart of the input sample loader.
- Collects NUMSAMPLES words that arrive as 4 parallel lanes per beat. Lane L, beat b holds sample index L*DEPTH+b, where DEPTH=NUMSAMPLES/4.
- Stores the beats, then streams all samples out serially in natural index order 0..NUMSAMPLES-1 over a valid/ready port.
- Sits at the tail of the datapath, feeding the output dump or a downstream consumer.

Parameters:
- WORDSIZE, 16, bits per sample word.
- NUMSAMPLES, 32, samples per frame. Must be a multiple of 4. DEPTH=NUMSAMPLES/4 beats per frame.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s  in  1  start level. Frame begins when s=1 in IDLE.
- in_valid  in  1  the 4 lane words are valid this cycle.
- data_in0  in  WORDSIZE  lane 0, sample b.
- data_in1  in  WORDSIZE  lane 1, sample DEPTH+b.
- data_in2  in  WORDSIZE  lane 2, sample 2*DEPTH+b.
- data_in3  in  WORDSIZE  lane 3, sample 3*DEPTH+b.
- out_ready  in  1  consumer accepts data_out.
- out_valid  out  1  data_out holds a valid sample.
- data_out  out  WORDSIZE  sample at out_index.
- out_index  out  clog2(NUMSAMPLES)  index of the current output sample.
- done  out  1  frame fully drained.
- error  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; beat counter and read counter = 0.
  - done=0, error=0, out_valid=0, data_out=0, out_index=0.
  - Buffer contents are don't-care.
  - Reset mid-frame abandons the frame with no partial output.
- States: IDLE, COLLECT, DRAIN, DONE. Encoding is 2 bits.
- IDLE:
  - done=0.
  - s=1 -> COLLECT; clear beat counter and error.
  - in_valid=1 while in IDLE sets error; data is dropped.
- COLLECT:
  - Each in_valid cycle writes lane L into slot L*DEPTH+beat, then beat++.
  - On the write with beat==DEPTH-1 -> DRAIN next cycle.
  - in_valid=0 stalls with no state change.
  - s is ignored in COLLECT.
- DRAIN:
  - out_valid=1, out_index=rd, data_out=sample[rd].
  - Transfer occurs when out_valid&&out_ready; then rd++.
  - data_out and out_index hold stable while out_ready=0.
  - Transfer with rd==NUMSAMPLES-1 -> DONE, done=1, out_valid=0 next cycle.
  - in_valid=1 in DRAIN sets error (overrun); the buffer is not modified.
- DONE:
  - done=1 held.
  - s=0 -> IDLE (done clears next cycle).
  - in_valid=1 sets error.
- Latency: first out_valid is the cycle after the last input beat is accepted. A full frame with out_ready tied high takes DEPTH + NUMSAMPLES cycles from first beat to done.
- error stays set until the next IDLE->COLLECT start or reset. It does not stop the FSM.
- data_out is combinational from the buffer read mux. All control outputs are registered.
- No arithmetic on data: words are stored and returned bit-exact.

Decomposition:
- Shared package:
  - state encodings IDLE/COLLECT/DRAIN/DONE;
  - LANES=4;
  - DEPTH and index-width localparams derived from NUMSAMPLES.
- Sub-module sample_bank:
  - one DEPTH x WORDSIZE bank with 1 write port and 1 read port;
  - instantiated 4 times, where lane L writes bank L at address beat;
  - read selects bank rd/DEPTH at address rd%DEPTH.

Test Plan:
- Ordered frame:
  - Stimulus: s=1, 8 consecutive in_valid beats with data_inL=8L+b (b=0..7), out_ready=1.
  - Response: data_out = 0x0000..0x001F in order; out_index matches; done rises 1 cycle after index 31; error=0.
- Backpressure:
  - Stimulus: same frame; out_ready toggles 1,0,0,1...
  - Response: no sample is dropped or duplicated; data_out and out_index hold across ready-low cycles.
- Input stalls:
  - Stimulus: in_valid gaps of 3 cycles between beats.
  - Response: output sequence is identical to the ordered frame; DRAIN starts only after the 8th beat.
- Overrun:
  - Stimulus: in_valid=1 during DRAIN at rd=5 with data 0xFFFF.
  - Response: error=1 sticky; drained values stay 0..31.
  - Then: the next start clears error.
- Reset mid-frame:
  - Stimulus: drop rst_n after beat 4.
  - Response: immediately out_valid=0, done=0, error=0, state IDLE.
  - Then: a new full frame drains correctly.
- Handshake with s:
  - Stimulus: hold s=1 after done.
  - Response: stays DONE with done=1.
  - Then: s=0 -> IDLE next cycle, done=0.
  - Then: s=1 again -> a second frame with data 0x100+idx streams correctly.

Source files
------------

// File: rtl/write_output_pkg.sv
// Shared types and sizing helpers for the result write-out block.
package write_output_pkg;

  // Parallel lanes delivered per input beat.
  localparam int unsigned LANES = 4;

  // Default frame geometry (the top derives its own values from NUMSAMPLES).
  localparam int unsigned DEF_NUMSAMPLES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Beats per frame: each beat carries one sample per lane.
  function automatic int unsigned depth_of(input int unsigned numsamples);
    return numsamples / LANES;
  endfunction

  // Address width for n entries, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_DEPTH = depth_of(DEF_NUMSAMPLES);
  localparam int unsigned DEF_IDXW  = width_of(DEF_NUMSAMPLES);

endpackage

// File: rtl/write_output_sample_bank.sv
// One lane's sample storage: single write port, asynchronous read port.
module sample_bank
  import write_output_pkg::*;
#(
  parameter  int unsigned WORDSIZE = 16,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  localparam int unsigned AW       = width_of(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WORDSIZE-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [WORDSIZE-1:0] rdata
);

  logic [WORDSIZE-1:0] mem [DEPTH];

  // Store the lane word at the current beat address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/write_output.sv
// Gathers a frame of 4-lane beats, then streams samples out in index order.
module write_output
  import write_output_pkg::*;
#(
  parameter  int unsigned WORDSIZE   = 16,
  parameter  int unsigned NUMSAMPLES = DEF_NUMSAMPLES,
  localparam int unsigned IDXW       = width_of(NUMSAMPLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s,
  input  logic                in_valid,
  input  logic [WORDSIZE-1:0] data_in0,
  input  logic [WORDSIZE-1:0] data_in1,
  input  logic [WORDSIZE-1:0] data_in2,
  input  logic [WORDSIZE-1:0] data_in3,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORDSIZE-1:0] data_out,
  output logic [IDXW-1:0]     out_index,
  output logic                done,
  output logic                error
);

  localparam int unsigned DEPTH = depth_of(NUMSAMPLES);
  localparam int unsigned BW    = width_of(DEPTH);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(DEPTH - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUMSAMPLES - 1);

  state_t            state, state_n;
  logic [BW-1:0]     beat, beat_n;
  logic [IDXW-1:0]   rd, rd_n;
  logic              done_n, error_n, out_valid_n;
  logic              wr_en;
  logic [BW-1:0]     rd_addr;
  logic [1:0]        rd_bank;
  logic [WORDSIZE-1:0] lane_in  [LANES];
  logic [WORDSIZE-1:0] lane_out [LANES];

  // Lane L lands in bank L; a sample index splits into bank and row.
  always_comb begin
    lane_in[0] = data_in0;
    lane_in[1] = data_in1;
    lane_in[2] = data_in2;
    lane_in[3] = data_in3;
    rd_bank    = 2'(32'(rd) / DEPTH);
    rd_addr    = BW'(32'(rd) % DEPTH);
  end

  assign wr_en = (state == COLLECT) && in_valid;

  for (genvar l = 0; l < LANES; l++) begin : g_bank
    sample_bank #(
      .WORDSIZE (WORDSIZE),
      .DEPTH    (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (wr_en),
      .waddr (beat),
      .wdata (lane_in[l]),
      .raddr (rd_addr),
      .rdata (lane_out[l])
    );
  end

  // Read mux is combinational; forced to zero whenever nothing is offered.
  assign data_out  = out_valid ? lane_out[rd_bank] : '0;
  assign out_index = rd;

  // Next-state and next control values; every output is taken from a register.
  always_comb begin
    state_n     = state;
    beat_n      = beat;
    rd_n        = rd;
    done_n      = done;
    error_n     = error;
    out_valid_n = out_valid;
    unique case (state)
      IDLE: begin
        done_n = 1'b0;
        if (in_valid) begin
          error_n = 1'b1;
        end
        // A start clears the sticky error even if stray data arrives with it.
        if (s) begin
          state_n = COLLECT;
          beat_n  = '0;
          rd_n    = '0;
          error_n = 1'b0;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          beat_n = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state_n     = DRAIN;
            rd_n        = '0;
            out_valid_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (in_valid) begin
          error_n = 1'b1;
        end
        if (out_ready) begin
          if (rd == LAST_IDX) begin
            state_n     = DONE;
            done_n      = 1'b1;
            out_valid_n = 1'b0;
          end else begin
            rd_n = rd + 1'b1;
          end
        end
      end
      DONE: begin
        done_n = 1'b1;
        if (in_valid) begin
          error_n = 1'b1;
        end
        if (!s) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers with asynchronous clear; buffer contents are not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      rd        <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      beat      <= beat_n;
      rd        <= rd_n;
      done      <= done_n;
      error     <= error_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_write_output.sv
// Directed self-checking bench for write_output.
module tb_write_output;

  localparam int NS  = 32;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rst_n, s, in_valid, out_ready;
  logic [15:0] d0, d1, d2, d3;
  logic        out_valid, done, error;
  logic [15:0] data_out;
  logic [4:0]  out_index;

  int total = 0;
  int bad   = 0;

  write_output #(
    .WORDSIZE   (16),
    .NUMSAMPLES (NS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .in_valid  (in_valid),
    .data_in0  (d0),
    .data_in1  (d1),
    .data_in2  (d2),
    .data_in3  (d3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_index (out_index),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_frame();
    s = 1'b1;
    in_valid = 1'b0;
    cyc();
    s = 1'b0;
    check("start_err_clear", error, 0);
    check("start_done_low", done, 0);
    check("start_no_valid", out_valid, 0);
  endtask

  task automatic send_beats(input int base, input int nbeats, input int gap);
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        cyc();
        check("no_early_drain", out_valid, 0);
      end
      in_valid = 1'b1;
      d0 = 16'(base + b);
      d1 = 16'(base + DEP + b);
      d2 = 16'(base + 2 * DEP + b);
      d3 = 16'(base + 3 * DEP + b);
      cyc();
      if (b < DEP - 1) check("no_early_drain", out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int base, input int mode, input int ovr_at, input logic hold_s);
    int   idx = 0;
    int   n = 0;
    bit   injected = 0;
    logic r;
    while (idx < NS && n < 400) begin
      check("out_valid", out_valid, 1);
      check("out_index", out_index, idx);
      check("data_out", data_out, 16'(base + idx));
      check("done_low", done, 0);
      if (injected) check("err_sticky", error, 1);
      in_valid = 1'b0;
      if (ovr_at >= 0 && idx == ovr_at && !injected) begin
        in_valid = 1'b1;
        d0 = 16'hFFFF; d1 = 16'hFFFF; d2 = 16'hFFFF; d3 = 16'hFFFF;
        injected = 1;
      end
      r = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      out_ready = r;
      s = hold_s;
      cyc();
      n++;
      if (r) idx++;
    end
    in_valid = 1'b0;
    check("drain_budget", idx, NS);
    check("done_high", done, 1);
    check("valid_low_after", out_valid, 0);
    check("error_end", error, (ovr_at >= 0) ? 1 : 0);
  endtask

  task automatic finish_frame(input logic held);
    if (held) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        check("done_held", done, 1);
        check("held_no_valid", out_valid, 0);
      end
    end
    s = 1'b0;
    cyc();
    check("done_clear", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; s = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    cyc();
    cyc();
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index", out_index, 0);
    check("rst_data", data_out, 0);
    rst_n = 1'b1;
    cyc();

    // Stray data while idle flags an error.
    in_valid = 1'b1;
    d0 = 16'h1234;
    cyc();
    in_valid = 1'b0;
    check("idle_err", error, 1);

    // Ordered frame.
    start_frame();
    send_beats(0, DEP, 0);
    drain(0, 0, -1, 1'b0);
    finish_frame(1'b0);

    // Backpressure.
    start_frame();
    send_beats(0, DEP, 0);
    drain(0, 1, -1, 1'b0);
    finish_frame(1'b0);

    // Input stalls.
    start_frame();
    send_beats(0, DEP, 3);
    drain(0, 0, -1, 1'b0);
    finish_frame(1'b0);

    // Overrun, then the next start clears error.
    start_frame();
    send_beats(0, DEP, 0);
    drain(0, 0, 5, 1'b0);
    finish_frame(1'b0);
    check("err_kept_idle", error, 1);
    start_frame();
    send_beats(0, DEP, 0);
    drain(0, 0, -1, 1'b0);
    finish_frame(1'b0);

    // Reset mid-frame, then a fresh frame.
    start_frame();
    send_beats(0, 4, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_index", out_index, 0);
    check("midrst_data", data_out, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("midrst_idle", out_valid, 0);
    start_frame();
    send_beats(16'h200, DEP, 0);
    drain(16'h200, 0, -1, 1'b0);
    finish_frame(1'b0);

    // Holding s after done, then a second frame.
    start_frame();
    send_beats(0, DEP, 0);
    drain(0, 0, -1, 1'b1);
    finish_frame(1'b1);
    start_frame();
    send_beats(16'h100, DEP, 0);
    drain(16'h100, 0, -1, 1'b0);
    finish_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "timeout");
  end

endmodule
